// File: rtl/sdram_aref_ctrl.sv
// sdram_aref_ctrl : SDRAM auto-refresh scheduler and PRECHARGE/AUTO REFRESH sequencer.
// Optional overrun reporting via macro SDRAM_AREF_OVERRUN_EN.  Rev 1.0
`default_nettype none

module sdram_aref_ctrl #(
  parameter int unsigned REF_INTERVAL = 750,
  parameter int unsigned TRP_CYC      = 2,
  parameter int unsigned TRC_CYC      = 7,
  parameter int unsigned AREF_NUM     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        aref_end,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_bank_addr,
  output logic [12:0] aref_addr
`ifdef SDRAM_AREF_OVERRUN_EN
  ,output logic       aref_overrun
  ,output logic [7:0] aref_miss_cnt
`endif
);

  localparam int unsigned INT_W   = $clog2(REF_INTERVAL);
  localparam int unsigned CYC_MAX = (TRC_CYC > TRP_CYC) ? TRC_CYC : TRP_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX);
  localparam int unsigned REF_W   = $clog2(AREF_NUM + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_PRECH     = 3'd2,
    S_TRP       = 3'd3,
    S_AREF      = 3'd4,
    S_TRC       = 3'd5,
    S_END       = 3'd6
  } state_t;

  state_t             state_q;
  logic               init_done_q;
  logic [INT_W-1:0]   int_cnt_q;
  logic [CYC_W-1:0]   cyc_cnt_q;
  logic [REF_W-1:0]   ref_cnt_q;
  logic               aref_req_q;
  logic               aref_end_q;
  logic [3:0]         cmd_q;
  logic [1:0]         ba_q;
  logic [12:0]        addr_q;

  logic wrap;
  logic grant;

  assign wrap  = init_done_q && (int_cnt_q == INT_W'(REF_INTERVAL - 1));
  assign grant = (state_q == S_IDLE) && aref_en && aref_req_q;

  // Outputs are registered from the next state, so a command appears in the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_INIT;
      init_done_q <= 1'b0;
      int_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      aref_req_q  <= 1'b0;
      aref_end_q  <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= 2'b11;
      addr_q      <= 13'h1fff;
    end else begin
      if (init_end) init_done_q <= 1'b1;
      if (init_done_q) int_cnt_q <= wrap ? '0 : int_cnt_q + INT_W'(1);

      if (grant)     aref_req_q <= 1'b0;
      else if (wrap) aref_req_q <= 1'b1;

      aref_end_q <= 1'b0;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'b11;
      addr_q     <= 13'h1fff;

      case (state_q)
        S_WAIT_INIT: if (init_done_q) state_q <= S_IDLE;
        S_IDLE: begin
          if (grant) begin
            state_q <= S_PRECH;
            cmd_q   <= CMD_PRE;
            addr_q  <= 13'h0400;
          end
        end
        S_PRECH: begin
          state_q   <= S_TRP;
          cyc_cnt_q <= '0;
        end
        S_TRP: begin
          if (cyc_cnt_q == CYC_W'(TRP_CYC - 2)) begin
            state_q <= S_AREF;
            cmd_q   <= CMD_AREF;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
          end
        end
        S_AREF: begin
          state_q   <= S_TRC;
          cyc_cnt_q <= '0;
          ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
        S_TRC: begin
          if (cyc_cnt_q == CYC_W'(TRC_CYC - 2)) begin
            if (ref_cnt_q < REF_W'(AREF_NUM)) begin
              state_q <= S_AREF;
              cmd_q   <= CMD_AREF;
            end else begin
              state_q    <= S_END;
              aref_end_q <= 1'b1;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
          end
        end
        S_END: begin
          state_q   <= S_IDLE;
          ref_cnt_q <= '0;
        end
        default: state_q <= S_WAIT_INIT;
      endcase
    end
  end

  assign aref_req       = aref_req_q;
  assign aref_end       = aref_end_q;
  assign aref_cmd       = cmd_q;
  assign aref_bank_addr = ba_q;
  assign aref_addr      = addr_q;

`ifdef SDRAM_AREF_OVERRUN_EN
  logic       overrun_q;
  logic [7:0] miss_q;

  // A wrap while a request is still pending (even one being granted this edge) loses an interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      miss_q    <= 8'h00;
    end else if (wrap && aref_req_q) begin
      overrun_q <= 1'b1;
      if (miss_q != 8'hff) miss_q <= miss_q + 8'd1;
    end
  end

  assign aref_overrun  = overrun_q;
  assign aref_miss_cnt = miss_q;
`else
  // Overruns are absorbed: aref_req just stays high until granted.
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdram_aref_ctrl.sv
// tb_sdram_aref_ctrl : directed vector bench for sdram_aref_ctrl (two parameter sets).
`default_nettype none

module tb_sdram_aref_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic clk = 1'b0;
  logic rst, init_end, en0, en1;

  logic        req0, end0, req1, end1;
  logic [3:0]  cmd0, cmd1;
  logic [1:0]  ba0, ba1;
  logic [12:0] addr0, addr1;
`ifdef SDRAM_AREF_OVERRUN_EN
  logic        ovr0, ovr1;
  logic [7:0]  miss0, miss1;
`endif

  always #5 clk = ~clk;

  sdram_aref_ctrl #(.REF_INTERVAL(20), .TRP_CYC(2), .TRC_CYC(7), .AREF_NUM(2)) u_dut0 (
    .clk(clk), .rst(rst), .init_end(init_end), .aref_en(en0),
    .aref_req(req0), .aref_end(end0), .aref_cmd(cmd0),
    .aref_bank_addr(ba0), .aref_addr(addr0)
`ifdef SDRAM_AREF_OVERRUN_EN
    , .aref_overrun(ovr0), .aref_miss_cnt(miss0)
`endif
  );

  sdram_aref_ctrl #(.REF_INTERVAL(20), .TRP_CYC(2), .TRC_CYC(2), .AREF_NUM(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_end(init_end), .aref_en(en1),
    .aref_req(req1), .aref_end(end1), .aref_cmd(cmd1),
    .aref_bank_addr(ba1), .aref_addr(addr1)
`ifdef SDRAM_AREF_OVERRUN_EN
    , .aref_overrun(ovr1), .aref_miss_cnt(miss1)
`endif
  );

  typedef struct packed {
    logic        en;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        req;
    logic        fin;
  } vec_t;

  vec_t seq0 [19];
  vec_t seq1 [7];

  int n_vec  = 0;
  int n_miss = 0;

  function automatic vec_t mk(input logic [3:0] cmd, input logic req, input logic fin);
    vec_t v;
    v.en   = 1'b1;
    v.cmd  = cmd;
    v.ba   = 2'b11;
    v.addr = (cmd == PRE) ? 13'h0400 : 13'h1fff;
    v.req  = req;
    v.fin  = fin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req0(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (req0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_req0", 32'(ok), 32'd1);
  endtask

  task automatic run_seq0(input bit drop);
    for (int k = 0; k < 19; k++) begin
      en0 = (drop && k >= 5) ? 1'b0 : seq0[k].en;
      chk($sformatf("seq0[%0d].cmd", k),  32'(cmd0),  32'(seq0[k].cmd));
      chk($sformatf("seq0[%0d].ba", k),   32'(ba0),   32'(seq0[k].ba));
      chk($sformatf("seq0[%0d].addr", k), 32'(addr0), 32'(seq0[k].addr));
      chk($sformatf("seq0[%0d].req", k),  32'(req0),  32'(seq0[k].req));
      chk($sformatf("seq0[%0d].end", k),  32'(end0),  32'(seq0[k].fin));
      step();
    end
    en0 = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Default-parameter trace relative to the grant cycle (row 0).
    for (int k = 0; k < 19; k++) seq0[k] = mk(NOP, (k == 0), 1'b0);
    seq0[1]  = mk(PRE,  1'b0, 1'b0);
    seq0[3]  = mk(AREF, 1'b0, 1'b0);
    seq0[10] = mk(AREF, 1'b0, 1'b0);
    seq0[17] = mk(NOP,  1'b0, 1'b1);
    for (int k = 0; k < 7; k++) seq1[k] = mk(NOP, (k == 0), 1'b0);
    seq1[1] = mk(PRE,  1'b0, 1'b0);
    seq1[3] = mk(AREF, 1'b0, 1'b0);
    seq1[5] = mk(NOP,  1'b0, 1'b1);

    rst = 1'b1; init_end = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst.cmd",  32'(cmd0),  32'(NOP));
    chk("rst.addr", 32'(addr0), 32'h1fff);
    chk("rst.ba",   32'(ba0),   32'h3);
    chk("rst.req",  32'(req0),  32'd0);
    chk("rst.end",  32'(end0),  32'd0);
`ifdef SDRAM_AREF_OVERRUN_EN
    chk("rst.miss", 32'(miss0), 32'd0);
    chk("rst.ovr",  32'(ovr0),  32'd0);
`endif
    repeat (7) step();

    init_end = 1'b1;
    repeat (20) step();
    chk("first.req_early", 32'(req0), 32'd0);
    chk("first.cmd_idle",  32'(cmd0), 32'(NOP));
    chk("first.addr_idle", 32'(addr0), 32'h1fff);
    step();
    chk("first.req_rise", 32'(req0), 32'd1);
    chk("dut1.req_rise",  32'(req1), 32'd1);

    step();
    run_seq0(1'b0);

    wait_req0(30);
    step();
    run_seq0(1'b1);

    // Leave the request ungranted for 45 cycles; two intervals wrap meanwhile.
    wait_req0(30);
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      if (req0 !== 1'b1) bad++;
      step();
    end
    chk("starve.req_low_cycles", 32'(bad), 32'd0);
    chk("starve.req", 32'(req0), 32'd1);
`ifdef SDRAM_AREF_OVERRUN_EN
    chk("starve.miss", 32'(miss0), 32'd2);
    chk("starve.ovr",  32'(ovr0),  32'd1);
`endif

    en0 = 1'b1;
    step();
    chk("abort.pre", 32'(cmd0), 32'(PRE));
    step(); step();
    chk("abort.aref", 32'(cmd0), 32'(AREF));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.cmd",  32'(cmd0),  32'(NOP));
    chk("abort.req",  32'(req0),  32'd0);
    chk("abort.end",  32'(end0),  32'd0);
    chk("abort.addr", 32'(addr0), 32'h1fff);
`ifdef SDRAM_AREF_OVERRUN_EN
    chk("abort.miss", 32'(miss0), 32'd0);
`endif

    // Grant held high with no pending request must be ignored.
    step();
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      if (cmd0 !== NOP || req0 !== 1'b0 || end0 !== 1'b0) bad++;
      step();
    end
    chk("ignore.bad_cycles", 32'(bad), 32'd0);
    en0 = 1'b0;
    chk("rearm.req_early", 32'(req0), 32'd0);
    step();
    chk("rearm.req_rise", 32'(req0), 32'd1);
    chk("dut1.rearm_req", 32'(req1), 32'd1);

    step();
    for (int k = 0; k < 7; k++) begin
      en1 = seq1[k].en;
      chk($sformatf("seq1[%0d].cmd", k),  32'(cmd1),  32'(seq1[k].cmd));
      chk($sformatf("seq1[%0d].addr", k), 32'(addr1), 32'(seq1[k].addr));
      chk($sformatf("seq1[%0d].req", k),  32'(req1),  32'(seq1[k].req));
      chk($sformatf("seq1[%0d].end", k),  32'(end1),  32'(seq1[k].fin));
      step();
    end
    en1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdram_aref_ctrl.md
Name: sdram_aref_ctrl

Overview:
Auto-refresh scheduler and command sequencer for the SDRAM controller.
- Times the refresh interval once initialisation completes.
- Raises a refresh request toward the arbiter.
- On grant, drives PRECHARGE-all followed by AREF_NUM AUTO REFRESH commands with tRP/tRC spacing, then pulses aref_end.
- Its command, bank and address outputs feed the arbiter's refresh channel; the arbiter provides aref_en.

Parameters:
REF_INTERVAL, 750, clock cycles between refresh requests (7.5 us at 100 MHz)
TRP_CYC, 2, cycles from PRECHARGE to first AUTO REFRESH (>=2)
TRC_CYC, 7, cycles from each AUTO REFRESH to the next command (>=2)
AREF_NUM, 2, AUTO REFRESH commands per granted refresh (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
init_end  input  1  initialisation finished; level, sampled every cycle
aref_en  input  1  grant from arbiter; high while arbiter is in its refresh state
aref_req  output  1  refresh request to arbiter (registered)
aref_end  output  1  one-cycle pulse: sequence complete
aref_cmd  output  4  {cs_n,ras_n,cas_n,we_n}
aref_bank_addr  output  2  SDRAM bank address
aref_addr  output  13  SDRAM address

Behaviour:
- Command codes:
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTO REFRESH = 4'b0001
- Reset:
  - State WAIT_INIT; init_done, interval counter, cycle counter and refresh counter all cleared.
  - aref_req=0, aref_end=0, aref_cmd=NOP, aref_bank_addr=2'b11, aref_addr=13'h1fff.
  - Reset mid-sequence aborts immediately to these values.
- init_done:
  - Set on the first cycle init_end=1; sticky until rst.
  - The interval counter is held at 0 until init_done=1.
- Interval counter:
  - Counts 0..REF_INTERVAL-1 every cycle after init_done, including during a refresh sequence.
  - At REF_INTERVAL-1 it wraps to 0 and sets aref_req on the next edge.
  - The first request appears REF_INTERVAL cycles after init_done sets.
- aref_req clears on the edge where state leaves IDLE for PRECH.
  - If a wrap coincides with that clear, clear wins and the wrap is an overrun.
  - If a wrap occurs while aref_req is already high, it is an overrun; aref_req stays 1.
- States: WAIT_INIT -> IDLE -> PRECH -> TRP -> AREF -> TRC -> (AREF | END) -> IDLE.
  - WAIT_INIT: go to IDLE when init_done.
  - IDLE: outputs idle values. If aref_en=1 and aref_req=1, go to PRECH. aref_en with aref_req=0 is ignored.
  - PRECH (1 cycle): cmd=PRECHARGE, addr=13'h0400 (A10=1, all banks), ba=2'b11.
  - TRP: cmd=NOP for TRP_CYC-1 cycles, then AREF.
  - AREF (1 cycle): cmd=AUTO REFRESH, addr=13'h1fff, ba=2'b11; refresh counter increments.
  - TRC: cmd=NOP for TRC_CYC-1 cycles. Then go to AREF if refresh counter < AREF_NUM, else END.
  - END (1 cycle): cmd=NOP, aref_end=1; refresh counter cleared; next state IDLE.
- Timing with defaults, grant seen in cycle 0:
  - PRECHARGE at cycle 1.
  - AUTO REFRESH at cycles 3 and 10.
  - aref_end at cycle 17.
  - General: END at 1+TRP_CYC+AREF_NUM*TRC_CYC.
- aref_en falling during PRECH..END is ignored; the sequence always completes.
- No command other than NOP is issued outside PRECH/AREF.
- Counter widths use $clog2 of the respective parameter; no overflow is possible.

Optional Feature:
Macro SDRAM_AREF_OVERRUN_EN.
- Defined:
  - Adds output aref_overrun (1 bit), a sticky flag set on any overrun and cleared only by rst.
  - Adds output aref_miss_cnt (8 bits), incremented per overrun and saturating at 8'hff.
  - Both reset to 0.
- Undefined: both ports are absent; overruns are silently absorbed and aref_req simply stays high.

Test Plan:
- REF_INTERVAL=20; rst 3 cycles, init_end=1 at cycle 10 -> aref_req rises 20 cycles after init_done set; aref_cmd=4'b0111, addr=13'h1fff before that.
- Grant aref_en=1 one cycle after aref_req, defaults TRP=2, TRC=7, NUM=2:
  - PRECHARGE with addr=13'h0400 one cycle after grant.
  - AUTO REFRESH at +3 and +10.
  - aref_end single pulse at +17.
  - aref_req low from +1.
- Drop aref_en at +5 mid-sequence -> identical command trace, aref_end still at +17.
- Hold aref_en=0 for 45 cycles after aref_req (REF_INTERVAL=20):
  - aref_req stays 1.
  - With SDRAM_AREF_OVERRUN_EN, aref_miss_cnt=2 and aref_overrun=1.
- Assert rst for 1 cycle at grant+4 -> next cycle aref_cmd=4'b0111, aref_req=0, aref_end=0; no new request until init_end is seen again plus 20 cycles.
- AREF_NUM=1, TRC_CYC=2 -> PRECHARGE +1, AUTO REFRESH +3, aref_end +5.
